// File: rtl/cart_mem_arbiter_if.sv
// cart_mem_arbiter_if: download, CPU and cart RAM signals of the cart memory arbiter
interface cart_mem_arbiter_if #(parameter int ADDR_W = 15);
   logic              dl_active, dl_wr, dl_wait, clear_req, cpu_ce, cpu_we, mem_we, busy, dl_overrun;
   logic [ADDR_W-1:0] dl_addr, cpu_addr, mem_addr, size_mask;
   logic [7:0]        dl_data, cpu_din, cpu_dout, mem_din, mem_q;
   modport slave (
      input  dl_active, dl_wr, dl_addr, dl_data, clear_req, cpu_ce, cpu_we, cpu_addr, cpu_din, mem_q,
      output dl_wait, cpu_dout, mem_addr, mem_din, mem_we, size_mask, busy, dl_overrun
   );
   modport master (
      output dl_active, dl_wr, dl_addr, dl_data, clear_req, cpu_ce, cpu_we, cpu_addr, cpu_din, mem_q,
      input  dl_wait, cpu_dout, mem_addr, mem_din, mem_we, size_mask, busy, dl_overrun
   );
endinterface

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: prioritised cart RAM port sharing between CPU, buffered download writes and a clear engine
module cart_mem_arbiter #(
   parameter int         ADDR_W    = 15,
   parameter logic [7:0] CLEAR_VAL = 8'hFF
) (
   input logic               clk,
   input logic               reset,
   cart_mem_arbiter_if.slave bus
);
   localparam logic [0:0] S_IDLE = 1'b0, S_CLEAR = 1'b1;
   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d, buf_addr_q, buf_addr_d, size_mask_q, size_mask_d, mem_addr_q, mem_addr_d;
   logic [7:0]        buf_data_q, buf_data_d;
   logic              buf_full_q, buf_full_d, overrun_q, overrun_d, force_q, force_d, dl_active_q, dl_active_d;
   logic              idle, last, commit, load, clear_go;
   always_comb begin
      idle        = state_q == S_IDLE;
      last        = &cnt_q;
      commit      = idle && !bus.cpu_ce && buf_full_q;
      load        = bus.dl_wr && (!buf_full_q || commit);
      clear_go    = idle && bus.clear_req && !bus.dl_active;
      state_d     = idle ? (clear_go ? S_CLEAR : S_IDLE) : (last ? S_IDLE : S_CLEAR);
      cnt_d       = clear_go ? '0 : (!idle && !last) ? cnt_q + 1'b1 : cnt_q;
      buf_full_d  = load || (buf_full_q && !commit);
      buf_addr_d  = load ? bus.dl_addr : buf_addr_q;
      buf_data_d  = load ? bus.dl_data : buf_data_q;
      overrun_d   = overrun_q || (bus.dl_wr && !load);
      dl_active_d = bus.dl_active;
      // a commit on the download start edge keeps its address
      size_mask_d = clear_go ? '0 : commit ? buf_addr_q : (bus.dl_active && !dl_active_q) ? '0 : size_mask_q;
      force_d     = bus.cpu_ce ? !idle : force_q;
      mem_addr_d  = !idle ? cnt_q : bus.cpu_ce ? bus.cpu_addr : buf_full_q ? buf_addr_q : mem_addr_q;
   end
   assign bus.mem_addr   = mem_addr_d;
   assign bus.mem_din    = !idle ? CLEAR_VAL : bus.cpu_ce ? bus.cpu_din : buf_data_q;
   assign bus.mem_we     = !reset && (!idle || (bus.cpu_ce ? bus.cpu_we : buf_full_q));
   assign bus.dl_wait    = buf_full_q;
   assign bus.busy       = !idle;
   assign bus.size_mask  = size_mask_q;
   assign bus.dl_overrun = overrun_q;
   assign bus.cpu_dout   = force_q ? CLEAR_VAL : bus.mem_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         buf_full_q  <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
         size_mask_q <= '0;
         overrun_q   <= 1'b0;
         force_q     <= 1'b0;
         dl_active_q <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_full_q  <= buf_full_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
         size_mask_q <= size_mask_d;
         overrun_q   <= overrun_d;
         force_q     <= force_d;
         dl_active_q <= dl_active_d;
         mem_addr_q  <= mem_addr_d;
      end
   end
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// tb_cart_mem_arbiter: scoreboard bench with a behavioural cart RAM and a clear-engine reference model
module tb_cart_mem_arbiter;
   localparam int AW = 15;
   localparam logic [AW-1:0] MAXA = '1;
   logic clk = 1'b0, reset = 1'b0;
   cart_mem_arbiter_if #(.ADDR_W(AW)) bus();
   cart_mem_arbiter #(.ADDR_W(AW), .CLEAR_VAL(8'hFF)) dut (.clk(clk), .reset(reset), .bus(bus));
   logic [7:0]    ram [0:(1<<AW)-1];
   logic [AW+7:0] dlq [$];
   int            n_chk = 0, n_err = 0;
   logic          m_clear = 1'b0, rd_pend = 1'b0;
   logic [AW-1:0] m_cnt = '0;
   logic [7:0]    rd_exp = '0;
   always #5 clk = ~clk;
   function automatic logic [7:0] init_val(input logic [AW-1:0] a);
      return a[7:0] ^ 8'h3C;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   always @(posedge clk) begin
      bus.mem_q <= ram[bus.mem_addr];
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_din;
   end
   // reference model: port ownership, clear sequence, read data and download commits
   always @(negedge clk) begin
      logic [AW+7:0] e;
      if (reset) begin
         chk("rst_we", bus.mem_we, 0);
         chk("rst_busy", bus.busy, 0);
         m_clear = 1'b0;
         rd_pend = 1'b0;
      end else begin
         if (rd_pend) chk("cpu_rd", bus.cpu_dout, rd_exp);
         rd_pend = bus.cpu_ce && !bus.cpu_we;
         rd_exp  = m_clear ? 8'hFF : ram[bus.cpu_addr];
         if (m_clear) begin
            chk("clr_port", {bus.busy, bus.mem_we, bus.mem_addr, bus.mem_din}, {1'b1, 1'b1, m_cnt, 8'hFF});
            if (m_cnt == MAXA) m_clear = 1'b0;
            else m_cnt = m_cnt + 1'b1;
         end else begin
            chk("idle_busy", bus.busy, 0);
            if (bus.cpu_ce && bus.cpu_we)
               chk("cpu_wr", {bus.mem_we, bus.mem_addr, bus.mem_din}, {1'b1, bus.cpu_addr, bus.cpu_din});
            else if (bus.cpu_ce)
               chk("cpu_rd_we", bus.mem_we, 0);
            else if (bus.mem_we) begin
               chk("commit_pending", dlq.size() != 0, 1);
               if (dlq.size() != 0) begin
                  e = dlq.pop_front();
                  chk("commit", {bus.mem_addr, bus.mem_din}, e);
               end
            end
            if (bus.clear_req && !bus.dl_active) begin
               m_clear = 1'b1;
               m_cnt   = '0;
            end
         end
      end
   end
   initial begin
      logic [AW-1:0] t2a [3];
      int n;
      t2a = '{15'h0000, 15'h1FFF, 15'h0005};
      for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(i[AW-1:0]);
      bus.dl_active = 0; bus.dl_wr = 0; bus.dl_addr = '0; bus.dl_data = '0; bus.clear_req = 0;
      bus.cpu_ce = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_wait", bus.dl_wait, 0);
      chk("rst_mask", bus.size_mask, 0);
      chk("rst_ovr", bus.dl_overrun, 0);
      step(); reset = 1'b0;
      // back-to-back download bytes
      bus.dl_active = 1; step();
      bus.dl_wr = 1; bus.dl_addr = 15'h0000; bus.dl_data = 8'hA5; dlq.push_back({15'h0000, 8'hA5});
      @(negedge clk); chk("t1_wait_T", bus.dl_wait, 0);
      step(); bus.dl_addr = 15'h1FFF; bus.dl_data = 8'h5A; dlq.push_back({15'h1FFF, 8'h5A});
      @(negedge clk); chk("t1_wait_T1", bus.dl_wait, 1); chk("t1_we_T1", bus.mem_we, 1);
      step(); bus.dl_wr = 0;
      @(negedge clk); chk("t1_wait_T2", bus.dl_wait, 1); chk("t1_we_T2", bus.mem_we, 1);
      step();
      @(negedge clk); chk("t1_wait_T3", bus.dl_wait, 0); chk("t1_we_T3", bus.mem_we, 0);
      chk("t1_mask", bus.size_mask, 15'h1FFF); chk("t1_ovr", bus.dl_overrun, 0);
      // CPU contention delays the commit
      step(); bus.dl_wr = 1; bus.dl_addr = 15'h0010; bus.dl_data = 8'h33; dlq.push_back({15'h0010, 8'h33});
      step(); bus.dl_wr = 0; bus.cpu_ce = 1;
      for (int k = 0; k < 3; k++) begin
         bus.cpu_addr = t2a[k];
         @(negedge clk); chk("t2_cpu_addr", bus.mem_addr, t2a[k]); chk("t2_wait", bus.dl_wait, 1);
         step();
      end
      bus.cpu_ce = 0;
      @(negedge clk); chk("t2_commit_we", bus.mem_we, 1); chk("t2_commit_addr", bus.mem_addr, 15'h0010);
      chk("t2_wait_T4", bus.dl_wait, 1);
      step();
      @(negedge clk); chk("t2_wait_T5", bus.dl_wait, 0); chk("t2_mask", bus.size_mask, 15'h0010);
      bus.cpu_ce = 1; bus.cpu_we = 1; bus.cpu_addr = 15'h0020; bus.cpu_din = 8'h77;
      step(); bus.cpu_we = 0;
      step(); bus.cpu_ce = 0;
      step(); chk("t2_ram_wr", ram[15'h0020], 8'h77);
      // overrun: second byte arrives while CPU blocks the commit
      bus.dl_wr = 1; bus.dl_addr = 15'h0040; bus.dl_data = 8'h11; dlq.push_back({15'h0040, 8'h11});
      step(); bus.dl_addr = 15'h0041; bus.dl_data = 8'h22; bus.cpu_ce = 1; bus.cpu_addr = 15'h0040;
      step(); bus.dl_wr = 0; bus.cpu_ce = 0;
      @(negedge clk); chk("t3_ovr", bus.dl_overrun, 1); chk("t3_commit_addr", bus.mem_addr, 15'h0040);
      repeat (4) step();
      @(negedge clk); chk("t3_ovr_sticky", bus.dl_overrun, 1);
      chk("t3_ram_40", ram[15'h0040], 8'h11); chk("t3_ram_41", ram[15'h0041], init_val(15'h0041));
      // clear request during download is ignored, dl_active rise empties size_mask
      bus.clear_req = 1; step(); bus.clear_req = 0;
      @(negedge clk); chk("t5_busy", bus.busy, 0);
      bus.dl_active = 0; step();
      bus.dl_active = 1; step();
      @(negedge clk); chk("t5_mask_rise", bus.size_mask, 0);
      bus.dl_active = 0; step();
      // reset mid-clear at counter 0x0100
      bus.clear_req = 1; step(); bus.clear_req = 0;
      repeat (256) step();
      reset = 1'b1;
      @(negedge clk); chk("t6_rst_we", bus.mem_we, 0);
      repeat (2) step(); reset = 1'b0;
      step();
      @(negedge clk); chk("t6_busy", bus.busy, 0); chk("t6_ovr", bus.dl_overrun, 0);
      chk("t6_ram_0ff", ram[15'h00FF], 8'hFF); chk("t6_ram_100", ram[15'h0100], init_val(15'h0100));
      chk("t6_ram_200", ram[15'h0200], init_val(15'h0200)); chk("t6_ram_000", ram[15'h0000], 8'hFF);
      // full clear with CPU traffic and a download byte pending
      bus.dl_wr = 1; bus.dl_addr = 15'h0123; bus.dl_data = 8'h44; dlq.push_back({15'h0123, 8'h44});
      step(); bus.dl_wr = 0;
      step(); bus.clear_req = 1;
      step(); bus.clear_req = 0; bus.cpu_ce = 1; bus.cpu_we = 1; bus.cpu_addr = 15'h0055; bus.cpu_din = 8'h12;
      step(); bus.cpu_we = 0;
      step(); bus.cpu_ce = 0; bus.dl_wr = 1; bus.dl_addr = 15'h0300; bus.dl_data = 8'h9C;
      dlq.push_back({15'h0300, 8'h9C});
      @(negedge clk); chk("t4_mask", bus.size_mask, 0);
      step(); bus.dl_wr = 0;
      @(negedge clk); chk("t4_wait", bus.dl_wait, 1);
      n = 0;
      while (m_clear && n < 40000) begin
         step();
         n++;
      end
      chk("t4_timeout", n < 40000, 1);
      @(negedge clk); chk("t4_commit_we", bus.mem_we, 1); chk("t4_commit_addr", bus.mem_addr, 15'h0300);
      step();
      @(negedge clk); chk("t4_wait_end", bus.dl_wait, 0); chk("t4_mask_end", bus.size_mask, 15'h0300);
      chk("t4_ram_55", ram[15'h0055], 8'hFF); chk("t4_ram_123", ram[15'h0123], 8'hFF);
      chk("t4_ram_max", ram[MAXA], 8'hFF); chk("t4_ram_300", ram[15'h0300], 8'h9C);
      step();
      chk("dlq_empty", dlq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/cart_mem_arbiter.md
# cart_mem_arbiter

Single-port cartridge RAM scheduler that shares the 32 KB cart memory between HPS download writes, CPU reads/writes and a cart-removal clear engine. It sits between the download interface, the console core's cart bus and the cart `spram`. It replaces the ad-hoc address and write-enable muxing with a prioritised schedule, a one-entry download write buffer with `wait` back-pressure, and a size-mask tracker.

## Interface
- `ADDR_W`, default 15: cart RAM address width (2^ADDR_W bytes).
- `CLEAR_VAL`, default 8'hFF: byte written to every location by the clear engine.

Ports (clock and reset first):
- `clk`  in  1: system clock; all state is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `dl_active`  in  1: cart download in progress.
- `dl_wr`  in  1: one-cycle download byte strobe.
- `dl_addr`  in  ADDR_W: download byte address.
- `dl_data`  in  8: download byte.
- `dl_wait`  out  1: download back-pressure; high while the holding buffer is full.
- `clear_req`  in  1: one-cycle request to wipe the cart RAM (Remove Cart).
- `cpu_ce`  in  1: CPU cart-access slot strobe.
- `cpu_we`  in  1: CPU write qualifier, valid with `cpu_ce`.
- `cpu_addr`  in  ADDR_W: CPU address.
- `cpu_din`  in  8: CPU write data.
- `cpu_dout`  out  8: CPU read data, valid the cycle after `cpu_ce`.
- `mem_addr`  out  ADDR_W: RAM address.
- `mem_din`  out  8: RAM write data.
- `mem_we`  out  1: RAM write enable.
- `mem_q`  in  8: RAM read data, 1-cycle synchronous latency.
- `size_mask`  out  ADDR_W: last committed download address; 0 means empty.
- `busy`  out  1: clear engine running.
- `dl_overrun`  out  1: sticky flag, set when a download byte is dropped.

## Operation
- States: IDLE and CLEAR.
- Reset state: IDLE, holding buffer empty, clear counter 0, `size_mask` 0, `dl_overrun` 0, read-force flag 0.
- Reset output values: `dl_wait`=0, `busy`=0, `mem_we`=0. `mem_we` is also forced to 0 for as long as `reset` is high.
- Memory port priority in IDLE:
  - CPU first: when `cpu_ce`=1, drive `mem_addr`=`cpu_addr`, `mem_din`=`cpu_din`, `mem_we`=`cpu_we`.
  - Holding buffer second: when `cpu_ce`=0 and the buffer is full, drive the buffered address and data with `mem_we`=1. This is a commit.
  - Otherwise: `mem_we`=0 and `mem_addr` holds its last value.
- CLEAR state:
  - Drive `mem_addr`=counter, `mem_din`=CLEAR_VAL, `mem_we`=1 every cycle.
  - The counter runs 0 to 2^ADDR_W−1, then the state returns to IDLE.
  - CPU writes are dropped.
  - CPU reads return CLEAR_VAL: the read-force flag is set on any `cpu_ce` in CLEAR and muxes `cpu_dout`.
  - A full holding buffer stays pending until the state returns to IDLE.
- Entering CLEAR: `clear_req`=1 while IDLE and `dl_active`=0. Entry zeroes `size_mask` and the counter.
  - `clear_req` during CLEAR is ignored.
  - `clear_req` while `dl_active`=1 is ignored.
- Holding buffer:
  - `dl_wr`=1 loads the buffer if it is empty, or if it is committing in the same cycle.
  - Otherwise the byte is dropped and `dl_overrun`←1. Only `reset` clears `dl_overrun`.
  - `dl_wait` equals the buffer-full flag.
- Size mask: each commit sets `size_mask`←committed address. A rising edge of `dl_active` sets `size_mask`←0. If that edge coincides with a commit, the commit wins.
- `cpu_dout`: equals `mem_q`, unless the read-force flag is set, in which case it is CLEAR_VAL.
- Reset mid-CLEAR aborts the clear; locations already written stay at CLEAR_VAL.

## Timing
- CPU read: `cpu_ce` at cycle T gives `cpu_dout` valid at T+1, with no added latency. A CPU write commits in cycle T.
- Download byte accepted at T:
  - Buffer full and `dl_wait`=1 from T+1.
  - Commit at the first cycle ≥T+1 with state IDLE and `cpu_ce`=0.
  - `dl_wait` falls the cycle after the commit.
  - Best case: `dl_wait` is high for one cycle only.
- Back-to-back `dl_wr` at T and T+1 with `cpu_ce`=0: both are accepted, since the T+1 strobe loads while the buffer commits.
- Clear duration: `busy`=1 from the cycle after `clear_req` for exactly 2^ADDR_W cycles. The first IDLE cycle follows the write to address 2^ADDR_W−1.
- Address arithmetic is unsigned ADDR_W bits; the clear counter terminates on all-ones and does not wrap.

## Test plan
- Download with `cpu_ce`=0: write 0xA5 to 0x0000 and 0x5A to 0x1FFF on consecutive cycles. Expect two `mem_we` pulses in consecutive cycles, `dl_wait` high 1 cycle per byte, `size_mask`=0x1FFF, `dl_overrun`=0.
- Contention: `dl_wr` to 0x0010 at T, `cpu_ce` held high T+1..T+3. Expect CPU addresses on the port T+1..T+3, the commit at T+4, `dl_wait` high T+1..T+4.
- Overrun: second `dl_wr` at T+1 while `cpu_ce`=1 blocks the commit. Expect the byte dropped, `dl_overrun`=1 sticky, and only the first byte written.
- Clear: pulse `clear_req` in IDLE with `dl_active`=0. Expect `busy` high for 32768 cycles, every address written with 0xFF, `size_mask`=0, CPU reads returning 0xFF and CPU writes dropped.
- Clear request during download: `clear_req` while `dl_active`=1 is ignored (`busy` stays 0). `dl_wr` arriving during CLEAR commits only after `busy` falls.
- Reset mid-clear at counter 0x0100: state returns to IDLE, `busy`=0, `mem_we`=0 while reset is high, and address 0x0200 keeps its prior contents.
